// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - CLINT-style machine timer and software interrupt block
//
// Purpose: 64-bit mtime counter advanced by a TICK_DIV prescaler, a 64-bit
// mtimecmp compare register producing mtip_o, and a one-bit msip register.
// All of them are accessed over a simple 32-bit request/response bus.
//
// Ports:
//   clk                 in   1   sole clock, rising edge
//   rst                 in   1   asynchronous active-high reset
//   timer_addr_i        in  32   bus byte address ([31:16] decoded against BASE_ADDR)
//   timer_valid_i       in   1   access request
//   timer_write_valid_i in   1   write qualifier (1 = write, 0 = read)
//   timer_wdata_i       in  32   write data
//   timer_rdata_o       out 32   registered read data
//   timer_rvalid_o      out  1   read data valid, one cycle after the read
//   mtip_o              out  1   registered (mtime >= mtimecmp)
//   msip_o              out  1   software interrupt pending
//
// Configuration macro: CLINT_TIMER_SNAPSHOT_EN
//   When defined, reading mtime[31:0] latches mtime[63:32] into a snapshot
//   register and reads of mtime[63:32] return that snapshot, so a lo-then-hi
//   read sequence yields a coherent 64-bit value.

module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] timer_addr_i,
  input  logic        timer_valid_i,
  input  logic        timer_write_valid_i,
  input  logic [31:0] timer_wdata_i,
  output logic [31:0] timer_rdata_o,
  output logic        timer_rvalid_o,
  output logic        mtip_o,
  output logic        msip_o
);

  localparam logic [15:0] OFF_MSIP      = 16'h0000;
  localparam logic [15:0] OFF_MTCMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_MTCMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO  = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI  = 16'hBFFC;
  localparam logic [15:0] PRESC_LAST    = 16'(TICK_DIV - 1);

  logic [15:0] r_presc;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_mtip;

  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic [15:0] w_off;
  logic        w_tick;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic [31:0] w_rdata_nx;
  logic [31:0] w_mtime_hi_rd;

  assign w_hit  = timer_valid_i && (timer_addr_i[31:16] == BASE_ADDR[31:16]);
  assign w_wr   = w_hit && timer_write_valid_i;
  assign w_rd   = w_hit && !timer_write_valid_i;
  assign w_off  = timer_addr_i[15:0];
  assign w_tick = (r_presc == PRESC_LAST);

  assign w_wr_mtime_lo = w_wr && (w_off == OFF_MTIME_LO);
  assign w_wr_mtime_hi = w_wr && (w_off == OFF_MTIME_HI);

`ifdef CLINT_TIMER_SNAPSHOT_EN
  logic [31:0] r_snap;

  // Latch the upper half alongside a low-half read so a following high-half
  // read cannot observe a carry that happened in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= 32'd0;
    end else if (w_rd && (w_off == OFF_MTIME_LO)) begin
      r_snap <= r_mtime[63:32];
    end
  end

  assign w_mtime_hi_rd = r_snap;
`else
  assign w_mtime_hi_rd = r_mtime[63:32];
`endif

  // Read mux works on current register values, so a read colliding with a
  // write or tick returns the pre-update value.
  always_comb begin
    w_rdata_nx = 32'd0;
    case (w_off)
      OFF_MSIP:     w_rdata_nx = {31'd0, r_msip};
      OFF_MTCMP_LO: w_rdata_nx = r_mtimecmp[31:0];
      OFF_MTCMP_HI: w_rdata_nx = r_mtimecmp[63:32];
      OFF_MTIME_LO: w_rdata_nx = r_mtime[31:0];
      OFF_MTIME_HI: w_rdata_nx = w_mtime_hi_rd;
      default:      w_rdata_nx = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= 16'd0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
      r_rdata    <= 32'd0;
      r_rvalid   <= 1'b0;
      r_mtip     <= 1'b0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;

      // A software write to either mtime half wins over the tick: the
      // written half is loaded, the other half is left alone, no carry.
      if (w_wr_mtime_lo || w_wr_mtime_hi) begin
        if (w_wr_mtime_lo) r_mtime[31:0]  <= timer_wdata_i;
        if (w_wr_mtime_hi) r_mtime[63:32] <= timer_wdata_i;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr && (w_off == OFF_MTCMP_LO)) r_mtimecmp[31:0]  <= timer_wdata_i;
      if (w_wr && (w_off == OFF_MTCMP_HI)) r_mtimecmp[63:32] <= timer_wdata_i;
      if (w_wr && (w_off == OFF_MSIP))     r_msip            <= timer_wdata_i[0];

      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rdata_nx;

      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  assign timer_rdata_o  = r_rdata;
  assign timer_rvalid_o = r_rvalid;
  assign mtip_o         = r_mtip;
  assign msip_o         = r_msip;

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - directed self-checking bench for clint_timer

module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        valid = 1'b0;
  logic        wvalid = 1'b0;
  logic [31:0] wdata = 32'd0;

  logic [31:0] rdata4, rdata1;
  logic        rvalid4, rvalid1, mtip4, mtip1, msip4, msip1;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] B4 = 32'h0200_0000;
  localparam logic [31:0] B1 = 32'h0400_0000;

`ifdef CLINT_TIMER_SNAPSHOT_EN
  localparam logic [31:0] SNAP_HI_EXP = 32'd0;
`else
  localparam logic [31:0] SNAP_HI_EXP = 32'd1;
`endif

  always #5 clk = ~clk;

  clint_timer #(.BASE_ADDR(B4), .TICK_DIV(4)) u_div4 (
    .clk                 (clk),
    .rst                 (rst),
    .timer_addr_i        (addr),
    .timer_valid_i       (valid),
    .timer_write_valid_i (wvalid),
    .timer_wdata_i       (wdata),
    .timer_rdata_o       (rdata4),
    .timer_rvalid_o      (rvalid4),
    .mtip_o              (mtip4),
    .msip_o              (msip4)
  );

  clint_timer #(.BASE_ADDR(B1), .TICK_DIV(1)) u_div1 (
    .clk                 (clk),
    .rst                 (rst),
    .timer_addr_i        (addr),
    .timer_valid_i       (valid),
    .timer_write_valid_i (wvalid),
    .timer_wdata_i       (wdata),
    .timer_rdata_o       (rdata1),
    .timer_rvalid_o      (rvalid1),
    .mtip_o              (mtip1),
    .msip_o              (msip1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; valid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    valid = 1'b0; wvalid = 1'b0;
  endtask

  // Called at a negedge; checks data and a one-cycle rvalid pulse.
  task automatic rd(input logic [31:0] a, input bit sel1, input logic [31:0] exp, input string tag);
    addr = a; valid = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, sel1 ? rvalid1 : rvalid4}, 32'd1);
    chk({tag, "_rdata"}, sel1 ? rdata1 : rdata4, exp);
    @(negedge clk);
    chk({tag, "_rvalid_drop"}, {31'd0, sel1 ? rvalid1 : rvalid4}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdata4", rdata4, 32'd0);
    chk("rst_rvalid4", {31'd0, rvalid4}, 32'd0);
    chk("rst_mtip4", {31'd0, mtip4}, 32'd0);
    chk("rst_msip4", {31'd0, msip4}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rst_mtip1", {31'd0, mtip1}, 32'd0);
    rst = 1'b0;

    // 40 edges at TICK_DIV=4 -> mtime = 10
    repeat (40) @(negedge clk);
    chk("div4_pre_rvalid", {31'd0, rvalid4}, 32'd0);
    rd(B4 | 32'hBFF8, 1'b0, 32'd10, "div4_mtime");

    // mtip rises one cycle after mtime reaches 20, falls after cmp hi write
    wr(B1 | 32'hBFF8, 32'd0);
    wr(B1 | 32'h4000, 32'd20);
    wr(B1 | 32'h4004, 32'd0);
    repeat (18) @(negedge clk);
    chk("mtip_before", {31'd0, mtip1}, 32'd0);
    @(negedge clk);
    chk("mtip_rise", {31'd0, mtip1}, 32'd1);
    wr(B1 | 32'h4004, 32'd1);
    chk("mtip_hold", {31'd0, mtip1}, 32'd1);
    @(negedge clk);
    chk("mtip_fall", {31'd0, mtip1}, 32'd0);
    rd(B1 | 32'h4004, 1'b1, 32'd1, "mtcmp_hi");

    // wrap from all-ones
    wr(B1 | 32'h4000, 32'hFFFF_FFFF);
    wr(B1 | 32'h4004, 32'hFFFF_FFFF);
    wr(B1 | 32'hBFF8, 32'hFFFF_FFFF);
    wr(B1 | 32'hBFFC, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("mtip_allones", {31'd0, mtip1}, 32'd1);
    rd(B1 | 32'hBFF8, 1'b1, 32'd0, "wrap_lo");
    chk("mtip_after_wrap", {31'd0, mtip1}, 32'd0);
    rd(B1 | 32'hBFFC, 1'b1, 32'd0, "wrap_hi");

    // write wins over tick
    wr(B1 | 32'hBFF8, 32'd5);
    rd(B1 | 32'hBFF8, 1'b1, 32'd5, "wr_vs_tick");

    // msip, unmapped, miss
    wr(B4, 32'hFFFF_FFFF);
    chk("msip_set", {31'd0, msip4}, 32'd1);
    rd(B4, 1'b0, 32'd1, "msip_rd");
    rd(B4 | 32'h1234, 1'b0, 32'd0, "unmapped");
    addr = 32'h0300_0000; valid = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    chk("miss_rvalid4", {31'd0, rvalid4}, 32'd0);
    chk("miss_rvalid1", {31'd0, rvalid1}, 32'd0);

    // lo-then-hi across a carry
    wr(B1 | 32'hBFFC, 32'd0);
    wr(B1 | 32'hBFF8, 32'hFFFF_FFFE);
    rd(B1 | 32'hBFF8, 1'b1, 32'hFFFF_FFFE, "snap_lo");
    rd(B1 | 32'hBFFC, 1'b1, SNAP_HI_EXP, "snap_hi");

    // reset with a read in flight, then counting resumes
    addr = B4 | 32'hBFF8; valid = 1'b1; wvalid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rvalid", {31'd0, rvalid4}, 32'd0);
    chk("rst_mid_msip", {31'd0, msip4}, 32'd0);
    valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", {31'd0, rvalid4}, 32'd0);
    repeat (7) @(negedge clk);
    rd(B4 | 32'hBFF8, 1'b0, 32'd2, "resume_mtime");
    rd(B4 | 32'h4004, 1'b0, 32'hFFFF_FFFF, "rst_mtcmp_hi");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
